spi_ram_arbiter: RTL and testbench

//  Shares the single-port RAM between two requesters: the SPI slave command path and a local host port.

---
 rtl/spi_ram_arbiter.sv | 95 +++++++++
 tb/tb_spi_ram_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - round-robin sharing of one single-port RAM between SPI command frames and a host port
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [9:0]           rx_data,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [7:0]           host_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic                 spi_ovf
);

  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, pend_addr;
  logic [7:0]           pend_data;
  logic                 pend_valid, pend_we;
  logic                 last_host;
  logic                 rd_inflight, rd_tag_host;
  logic                 grant_spi, grant_host;
  logic                 spi_access, slot_free, capture;

  // The side that did not win last time has priority when both request.
  always_comb begin
    grant_spi  = rst_n & pend_valid & (~host_req | last_host);
    grant_host = rst_n & host_req & (~pend_valid | ~last_host);
    host_gnt   = grant_host;
    ram_en     = grant_spi | grant_host;
    ram_we     = grant_spi ? pend_we   : (grant_host & host_we);
    ram_addr   = grant_spi ? pend_addr : host_addr;
    ram_wdata  = grant_spi ? pend_data : host_wdata;
    spi_access = rx_valid & rx_data[8];
    slot_free  = ~pend_valid | grant_spi;
    capture    = spi_access & slot_free;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      pend_addr   <= '0;
      pend_data   <= '0;
      pend_valid  <= 1'b0;
      pend_we     <= 1'b0;
      last_host   <= 1'b1;
      rd_inflight <= 1'b0;
      rd_tag_host <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      spi_ovf     <= 1'b0;
    end else begin
      if (rx_valid && rx_data[9:8] == 2'b00) wr_addr <= rx_data[ADDR_SIZE-1:0];
      if (rx_valid && rx_data[9:8] == 2'b10) rd_addr <= rx_data[ADDR_SIZE-1:0];

      // The address is frozen into the slot here, so later address frames never retarget it.
      if (capture) begin
        pend_valid <= 1'b1;
        pend_we    <= ~rx_data[9];
        pend_addr  <= rx_data[9] ? rd_addr : wr_addr;
        pend_data  <= rx_data[7:0];
        if (AUTO_INC) begin
          if (rx_data[9]) rd_addr <= rd_addr + ADDR_SIZE'(1);
          else            wr_addr <= wr_addr + ADDR_SIZE'(1);
        end
      end else if (grant_spi) begin
        pend_valid <= 1'b0;
      end

      if (spi_access && !slot_free) spi_ovf <= 1'b1;
      if (ram_en) last_host <= grant_host;

      rd_inflight <= ram_en & ~ram_we;
      rd_tag_host <= grant_host;
      tx_valid    <= rd_inflight & ~rd_tag_host;
      host_rvalid <= rd_inflight & rd_tag_host;
      if (rd_inflight && !rd_tag_host) tx_data    <= ram_rdata;
      if (rd_inflight &&  rd_tag_host) host_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - scoreboard bench for spi_ram_arbiter (AUTO_INC=0 and AUTO_INC=1 instances)
module tb_spi_ram_arbiter;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [9:0] rx_data = '0;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       tx_valid, host_gnt, host_rvalid, ram_en, ram_we, spi_ovf;
  logic [7:0] tx_data, host_rdata, ram_addr, ram_wdata, ram_rdata;

  logic       ai_rx_valid = 1'b0;
  logic [9:0] ai_rx_data = '0;
  logic       ai_tx_valid, ai_host_gnt, ai_host_rvalid, ai_ram_en, ai_ram_we, ai_spi_ovf;
  logic [7:0] ai_tx_data, ai_host_rdata, ai_ram_addr, ai_ram_wdata, ai_ram_rdata;

  spi_ram_arbiter #(.ADDR_SIZE(8), .AUTO_INC(1'b0)) dut (
    .CLK(CLK), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .spi_ovf(spi_ovf));

  spi_ram_arbiter #(.ADDR_SIZE(8), .AUTO_INC(1'b1)) dut_ai (
    .CLK(CLK), .rst_n(rst_n), .rx_valid(ai_rx_valid), .rx_data(ai_rx_data),
    .tx_valid(ai_tx_valid), .tx_data(ai_tx_data), .host_req(1'b0), .host_we(1'b0),
    .host_addr(8'h00), .host_wdata(8'h00), .host_gnt(ai_host_gnt),
    .host_rvalid(ai_host_rvalid), .host_rdata(ai_host_rdata), .ram_en(ai_ram_en), .ram_we(ai_ram_we),
    .ram_addr(ai_ram_addr), .ram_wdata(ai_ram_wdata), .ram_rdata(ai_ram_rdata), .spi_ovf(ai_spi_ovf));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  always @(posedge CLK) if (ram_en) begin
    if (ram_we) mem0[ram_addr] <= ram_wdata; else ram_rdata <= mem0[ram_addr];
  end
  always @(posedge CLK) if (ai_ram_en) begin
    if (ai_ram_we) mem1[ai_ram_addr] <= ai_ram_wdata; else ai_ram_rdata <= mem1[ai_ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t exp_tx[$];
  exp_t exp_host[$];
  exp_t exp_ai[$];

  always @(negedge CLK) begin
    exp_t e;
    if (tx_valid) begin
      n_tests++;
      if (exp_tx.size() == 0) begin
        n_fail++; $display("FAIL tx_unexpected: got tx_valid data=%h @%0d, required no pulse", tx_data, cyc);
      end else begin
        e = exp_tx.pop_front();
        if (tx_data !== e.data || cyc != e.cyc) begin
          n_fail++; $display("FAIL tx_read: got %h @%0d, required %h @%0d", tx_data, cyc, e.data, e.cyc);
        end
      end
    end
    if (host_rvalid) begin
      n_tests++;
      if (exp_host.size() == 0) begin
        n_fail++; $display("FAIL host_unexpected: got host_rvalid data=%h @%0d, required no pulse", host_rdata, cyc);
      end else begin
        e = exp_host.pop_front();
        if (host_rdata !== e.data || cyc != e.cyc) begin
          n_fail++; $display("FAIL host_read: got %h @%0d, required %h @%0d", host_rdata, cyc, e.data, e.cyc);
        end
      end
    end
    if (ai_tx_valid) begin
      n_tests++;
      if (exp_ai.size() == 0) begin
        n_fail++; $display("FAIL ai_tx_unexpected: got data=%h @%0d, required no pulse", ai_tx_data, cyc);
      end else begin
        e = exp_ai.pop_front();
        if (ai_tx_data !== e.data || cyc != e.cyc) begin
          n_fail++; $display("FAIL ai_tx_read: got %h @%0d, required %h @%0d", ai_tx_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic frame(input logic [1:0] c, input logic [7:0] p);
    rx_valid = 1'b1; rx_data = {c, p};
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic ai_frame(input logic [1:0] c, input logic [7:0] p);
    ai_rx_valid = 1'b1; ai_rx_data = {c, p};
    tick();
    ai_rx_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
    n_tests++;
    if (exp_tx.size() != 0 || exp_host.size() != 0 || exp_ai.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d/%0d outstanding reads, required 0/0/0",
               exp_tx.size(), exp_host.size(), exp_ai.size());
      exp_tx.delete(); exp_host.delete(); exp_ai.delete();
    end
  endtask

  task automatic test_reset();
    host_req = 1'b1;
    #1;
    n_tests++;
    if ({host_gnt, ram_en, tx_valid, host_rvalid, spi_ovf} !== 5'b0 || tx_data !== 8'h00 || host_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b en=%b txv=%b hrv=%b ovf=%b tx=%h hr=%h, required all 0",
               host_gnt, ram_en, tx_valid, host_rvalid, spi_ovf, tx_data, host_rdata);
    end
    host_req = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spi_rw();
    int f;
    frame(2'b00, 8'h0F);
    frame(2'b01, 8'hA5);
    rx_valid = 1'b1; rx_data = {2'b10, 8'h0F};
    #1;
    n_tests++;
    if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 8'h0F || ram_wdata !== 8'hA5) begin
      n_fail++; $display("FAIL spi_write_issue: got en=%b we=%b a=%h d=%h, required 1 1 0f a5", ram_en, ram_we, ram_addr, ram_wdata);
    end
    tick();
    rx_valid = 1'b0;
    f = cyc;
    frame(2'b11, 8'h00);
    n_tests++;
    if ({ram_en, ram_we} !== 2'b10 || ram_addr !== 8'h0F) begin
      n_fail++; $display("FAIL spi_read_issue: got en=%b we=%b a=%h, required 1 0 0f", ram_en, ram_we, ram_addr);
    end
    exp_tx.push_back('{8'hA5, f + 3});
    repeat (4) tick();
    n_tests++;
    if (mem0[8'h0F] !== 8'hA5 || tx_data !== 8'hA5) begin
      n_fail++; $display("FAIL spi_rw_state: got ram=%h tx_data=%h, required a5 a5", mem0[8'h0F], tx_data);
    end
    drain(1);
  endtask

  task automatic test_no_inc();
    frame(2'b00, 8'h41);
    frame(2'b01, 8'h99);
    frame(2'b00, 8'h40);
    frame(2'b01, 8'h11);
    frame(2'b01, 8'h22);
    repeat (3) tick();
    n_tests++;
    if (mem0[8'h40] !== 8'h22 || mem0[8'h41] !== 8'h99) begin
      n_fail++; $display("FAIL no_inc: got ram[40]=%h ram[41]=%h, required 22 99", mem0[8'h40], mem0[8'h41]);
    end
  endtask

  task automatic test_host_contend();
    int ha = 0;
    int f  = -10;
    logic exp_gnt;
    for (int k = 0; k < 4; k++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'(8'h20 + k); host_wdata = 8'(8'h30 + k * 17);
      #1;
      n_tests++;
      if (host_gnt !== 1'b1) begin
        n_fail++; $display("FAIL host_write_gnt: got %b, required 1", host_gnt);
      end
      tick();
    end
    host_req = 1'b0;
    frame(2'b10, 8'h0F);
    for (int i = 0; i < 8; i++) begin
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'(8'h20 + ha % 4);
      rx_valid = (i == 1 || i == 4); rx_data = {2'b11, 8'h00};
      if (rx_valid) f = cyc;
      #1;
      exp_gnt = (i != 2 && i != 5);
      n_tests++;
      if (host_gnt !== exp_gnt || ram_en !== 1'b1) begin
        n_fail++; $display("FAIL alternate_gnt[%0d]: got gnt=%b en=%b, required gnt=%b en=1", i, host_gnt, ram_en, exp_gnt);
      end
      if (host_gnt === 1'b1) begin
        exp_host.push_back('{8'(8'h30 + (ha % 4) * 17), cyc + 2});
        ha++;
      end else if (cyc == f + 1) begin
        n_tests++;
        if (ram_addr !== 8'h0F || ram_we !== 1'b0) begin
          n_fail++; $display("FAIL spi_contend_issue: got a=%h we=%b, required 0f 0", ram_addr, ram_we);
        end
        exp_tx.push_back('{8'hA5, cyc + 2});
      end
      tick();
    end
    host_req = 1'b0; rx_valid = 1'b0;
    drain(4);
  endtask

  task automatic test_overflow();
    n_tests++;
    if (spi_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b, required 0", spi_ovf);
    end
    frame(2'b10, 8'h21);
    frame(2'b11, 8'h00);
    rx_valid = 1'b1; rx_data = {2'b11, 8'h00};
    #1;
    n_tests++;
    if (ram_en !== 1'b1 || host_gnt !== 1'b0) begin
      n_fail++; $display("FAIL ovf_first_issue: got en=%b gnt=%b, required 1 0", ram_en, host_gnt);
    end
    exp_tx.push_back('{8'h41, cyc + 2});
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h22;
    #1;
    n_tests++;
    if (host_gnt !== 1'b1 || ram_addr !== 8'h22) begin
      n_fail++; $display("FAIL ovf_host_wins: got gnt=%b a=%h, required 1 22", host_gnt, ram_addr);
    end
    exp_host.push_back('{8'h52, cyc + 2});
    tick();
    rx_valid = 1'b0; host_req = 1'b0;
    #1;
    n_tests++;
    if (spi_ovf !== 1'b1 || ram_en !== 1'b1 || host_gnt !== 1'b0 || ram_addr !== 8'h21) begin
      n_fail++; $display("FAIL ovf_set: got ovf=%b en=%b gnt=%b a=%h, required 1 1 0 21", spi_ovf, ram_en, host_gnt, ram_addr);
    end
    exp_tx.push_back('{8'h41, cyc + 2});
    tick();
    n_tests++;
    if (ram_en !== 1'b0) begin
      n_fail++; $display("FAIL ovf_dropped: got en=%b, required 0", ram_en);
    end
    drain(4);
  endtask

  task automatic test_reset_priority();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    frame(2'b10, 8'h23);
    frame(2'b11, 8'h00);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    #1;
    n_tests++;
    if (host_gnt !== 1'b0 || ram_en !== 1'b1 || ram_addr !== 8'h23) begin
      n_fail++; $display("FAIL first_grant_spi: got gnt=%b en=%b a=%h, required 0 1 23", host_gnt, ram_en, ram_addr);
    end
    exp_tx.push_back('{8'h63, cyc + 2});
    tick();
    n_tests++;
    if (host_gnt !== 1'b1) begin
      n_fail++; $display("FAIL second_grant_host: got %b, required 1", host_gnt);
    end
    exp_host.push_back('{8'h30, cyc + 2});
    tick();
    host_req = 1'b0;
    drain(4);
  endtask

  task automatic test_reset_mid();
    frame(2'b10, 8'h20);
    frame(2'b11, 8'h00);
    n_tests++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL mid_read_issue: got en=%b we=%b, required 1 0", ram_en, ram_we);
    end
    tick();
    rst_n = 1'b0; host_req = 1'b1;
    #1;
    n_tests++;
    if (host_gnt !== 1'b0 || ram_en !== 1'b0) begin
      n_fail++; $display("FAIL gnt_in_reset: got gnt=%b en=%b, required 0 0", host_gnt, ram_en);
    end
    repeat (2) tick();
    host_req = 1'b0; rst_n = 1'b1;
    drain(5);
    n_tests++;
    if (tx_data !== 8'h00 || host_rdata !== 8'h00 || spi_ovf !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_regs: got tx=%h hr=%h ovf=%b, required 00 00 0", tx_data, host_rdata, spi_ovf);
    end
    rx_valid = 1'b1; rx_data = {2'b01, 8'h77};
    tick();
    rx_valid = 1'b1; rx_data = {2'b11, 8'h00};
    #1;
    n_tests++;
    if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 8'h00 || ram_wdata !== 8'h77) begin
      n_fail++; $display("FAIL wr_addr_reset: got en=%b we=%b a=%h d=%h, required 1 1 00 77", ram_en, ram_we, ram_addr, ram_wdata);
    end
    tick();
    rx_valid = 1'b0;
    n_tests++;
    if ({ram_en, ram_we} !== 2'b10 || ram_addr !== 8'h00) begin
      n_fail++; $display("FAIL rd_addr_reset: got en=%b we=%b a=%h, required 1 0 00", ram_en, ram_we, ram_addr);
    end
    exp_tx.push_back('{8'h77, cyc + 2});
    drain(4);
  endtask

  task automatic test_auto_inc();
    int n;
    ai_frame(2'b00, 8'hFF);
    ai_frame(2'b01, 8'h11);
    ai_frame(2'b01, 8'h22);
    repeat (2) tick();
    n_tests++;
    if (mem1[8'hFF] !== 8'h11 || mem1[8'h00] !== 8'h22) begin
      n_fail++; $display("FAIL auto_inc_wrap: got ram[ff]=%h ram[00]=%h, required 11 22", mem1[8'hFF], mem1[8'h00]);
    end
    ai_frame(2'b10, 8'hFF);
    n = cyc;
    exp_ai.push_back('{8'h11, n + 3});
    exp_ai.push_back('{8'h22, n + 4});
    ai_frame(2'b11, 8'h00);
    ai_frame(2'b11, 8'h00);
    drain(5);
    n_tests++;
    if ({ai_host_gnt, ai_host_rvalid, ai_spi_ovf} !== 3'b0 || ai_host_rdata !== 8'h00) begin
      n_fail++; $display("FAIL auto_inc_idle_host: got gnt=%b rv=%b ovf=%b hr=%h, required 0 0 0 00",
                         ai_host_gnt, ai_host_rvalid, ai_spi_ovf, ai_host_rdata);
    end
  endtask

  initial begin
    repeat (2) tick();
    test_reset();
    test_spi_rw();
    test_no_inc();
    test_host_contend();
    test_overflow();
    test_reset_priority();
    test_reset_mid();
    test_auto_inc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
